// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch front end. It issues read requests to instruction
//   memory at the current PC and holds the PC until the memory acknowledges.
//   The returned word goes into a registered output slot toward decode. A
//   one-entry skid buffer catches a word that returns while decode is
//   stalled. A redirect (taken branch/jump) flushes the fetch path. A
//   request that is still outstanding when a redirect arrives is drained,
//   and its data is discarded.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   pc_i                 current PC from the PC register
//   pc_hold_o            1 = PC holds, 0 = PC loads its next value
//   imem_req_o           instruction-memory read request
//   imem_addr_o          instruction-memory read address
//   imem_ack_i           read data valid this cycle (qualified by imem_req_o)
//   imem_rdata_i         fetched instruction word
//   redirect_i           branch/jump taken; flush, PC loads target
//   id_stall_i           decode cannot accept (qualified by valid_o)
//   valid_o              output slot holds a fetched instruction
//   instr_o, pc_o,
//   pc_plus4_o           registered instruction, its address, address+4
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter int N_BITS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_BITS-1:0] pc_i,
   output logic              pc_hold_o,
   output logic              imem_req_o,
   output logic [N_BITS-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [N_BITS-1:0] imem_rdata_i,
   input  logic              redirect_i,
   input  logic              id_stall_i,
   output logic              valid_o,
   output logic [N_BITS-1:0] instr_o,
   output logic [N_BITS-1:0] pc_o,
   output logic [N_BITS-1:0] pc_plus4_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [N_BITS-1:0] addr_q, addr_d;
   logic              valid_q, valid_d;
   logic [N_BITS-1:0] instr_q, instr_d;
   logic [N_BITS-1:0] pc_q, pc_d;
   logic [N_BITS-1:0] pc4_q, pc4_d;
   logic [N_BITS-1:0] skid_instr_q, skid_instr_d;
   logic [N_BITS-1:0] skid_pc_q, skid_pc_d;

   logic req_w, ack_w, slot_free_w;

   assign req_w       = (state_q == S_REQ) || (state_q == S_DRAIN);
   // An ack only counts while a request is actually on the bus.
   assign ack_w       = imem_ack_i && req_w;
   // The stall input only matters when the slot holds something.
   assign slot_free_w = !valid_q || !id_stall_i;

   assign imem_req_o  = req_w;
   // DRAIN replays the captured address; the PC has already moved on.
   assign imem_addr_o = (state_q == S_DRAIN) ? addr_q : pc_i;
   assign valid_o     = valid_q;
   assign instr_o     = instr_q;
   assign pc_o        = pc_q;
   assign pc_plus4_o  = pc4_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      pc4_d        = pc4_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      pc_hold_o    = 1'b1;

      // Decode consumed the slot and nothing new arrives: empty it.
      if (valid_q && !id_stall_i) valid_d = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_REQ;

         S_REQ: begin
            addr_d = pc_i;
            if (redirect_i) begin
               pc_hold_o = 1'b0;
               valid_d   = 1'b0;
               // Without an ack the memory still owes us a word.
               state_d   = ack_w ? S_REQ : S_DRAIN;
            end else if (ack_w) begin
               pc_hold_o = 1'b0;
               if (slot_free_w) begin
                  instr_d = imem_rdata_i;
                  pc_d    = pc_i;
                  pc4_d   = pc_i + N_BITS'(4);
                  valid_d = 1'b1;
               end else begin
                  skid_instr_d = imem_rdata_i;
                  skid_pc_d    = pc_i;
                  state_d      = S_FULL;
               end
            end
         end

         S_FULL: begin
            if (redirect_i) begin
               pc_hold_o = 1'b0;
               valid_d   = 1'b0;
               state_d   = S_REQ;
            end else if (!id_stall_i) begin
               instr_d = skid_instr_q;
               pc_d    = skid_pc_q;
               pc4_d   = skid_pc_q + N_BITS'(4);
               valid_d = 1'b1;
               state_d = S_REQ;
            end
         end

         default: begin // S_DRAIN
            if (redirect_i) begin
               pc_hold_o = 1'b0;
               valid_d   = 1'b0;
            end else if (ack_w) begin
               state_d = S_REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         valid_q      <= 1'b0;
         instr_q      <= '0;
         pc_q         <= '0;
         pc4_q        <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         pc4_q        <= pc4_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk, reset;
   logic [31:0] pc_i, imem_addr_o, imem_rdata_i, instr_o, pc_o, pc_plus4_o;
   logic        pc_hold_o, imem_req_o, imem_ack_i, redirect_i, id_stall_i, valid_o;

   fetch_stage #(.N_BITS(32)) dut (
      .clk(clk), .reset(reset), .pc_i(pc_i), .pc_hold_o(pc_hold_o),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
      .redirect_i(redirect_i), .id_stall_i(id_stall_i), .valid_o(valid_o),
      .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;

   // Behavioural model: a started flag, one outstanding orphaned request,
   // a pending-word queue (capacity 1) and the output slot contents.
   typedef struct packed { logic [31:0] instr; logic [31:0] pc; } word_t;
   word_t       pend_q[$];
   bit          m_started, m_orphan, m_valid;
   logic [31:0] m_orphan_addr, m_instr, m_pc, pc_m;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend_q.delete();
      m_started = 0; m_orphan = 0; m_valid = 0;
      m_orphan_addr = '0; m_instr = '0; m_pc = '0;
      pc_m = 32'h0040_0000;
   endtask

   // Asynchronous reset: asserted between edges and checked right away.
   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_req", {31'd0, imem_req_o}, 32'd0);
      chk("rst_hold", {31'd0, pc_hold_o}, 32'd1);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_pc4", pc_plus4_o, 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare against the model, advance it.
   task automatic step(input bit ack, input logic [31:0] rd, input bit rdr,
                       input logic [31:0] tgt, input bit st);
      bit          e_req, e_hold, ack_eff, fetching;
      logic [31:0] e_addr;
      word_t       w;
      @(negedge clk);
      imem_ack_i = ack; imem_rdata_i = rd; redirect_i = rdr;
      id_stall_i = st; pc_i = pc_m;
      #1;
      fetching = m_started && !m_orphan && (pend_q.size() == 0);
      e_req    = m_orphan || fetching;
      e_addr   = m_orphan ? m_orphan_addr : pc_m;
      if (!m_started)      e_hold = 1'b1;
      else if (rdr)        e_hold = 1'b0;
      else if (!fetching)  e_hold = 1'b1;
      else                 e_hold = !ack;
      ack_eff = ack && e_req;

      chk("req", {31'd0, imem_req_o}, {31'd0, e_req});
      if (e_req) chk("addr", imem_addr_o, e_addr);
      chk("hold", {31'd0, pc_hold_o}, {31'd0, e_hold});
      chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
      if (m_valid) begin
         chk("instr", instr_o, m_instr);
         chk("pc", pc_o, m_pc);
         chk("pc4", pc_plus4_o, m_pc + 32'd4);
      end

      if (!m_started) begin
         m_started = 1;
      end else if (rdr) begin
         m_valid = 0;
         pend_q.delete();
         if (fetching && !ack_eff) begin
            m_orphan = 1; m_orphan_addr = pc_m;
         end
      end else if (m_orphan) begin
         if (ack_eff) m_orphan = 0;
         if (m_valid && !st) m_valid = 0;
      end else if (pend_q.size() != 0) begin
         if (!st) begin
            w = pend_q.pop_front();
            m_instr = w.instr; m_pc = w.pc; m_valid = 1;
         end
      end else if (ack_eff) begin
         if (!m_valid || !st) begin
            m_instr = rd; m_pc = pc_m; m_valid = 1;
         end else begin
            w.instr = rd; w.pc = pc_m;
            pend_q.push_back(w);
         end
      end else if (m_valid && !st) begin
         m_valid = 0;
      end

      if (!e_hold) pc_m = rdr ? tgt : pc_m + 32'd4;
   endtask

   initial begin
      logic [31:0] r, tgt;
      reset = 1'b1; imem_ack_i = 0; imem_rdata_i = '0; redirect_i = 0;
      id_stall_i = 0; pc_i = '0;
      do_reset();

      // Directed scenario with hand-computed literals.
      step(0, 0, 0, 0, 0);                               // IDLE
      chk("idle_req", {31'd0, imem_req_o}, 32'd0);
      chk("idle_hold", {31'd0, pc_hold_o}, 32'd1);
      step(1, 32'h2008_0005, 0, 0, 0);                   // first fetch, ack
      chk("first_addr", imem_addr_o, 32'h0040_0000);
      chk("first_hold", {31'd0, pc_hold_o}, 32'd0);
      step(0, 0, 0, 0, 1);                               // delayed ack 1
      chk("first_valid", {31'd0, valid_o}, 32'd1);
      chk("first_instr", instr_o, 32'h2008_0005);
      chk("first_pc", pc_o, 32'h0040_0000);
      chk("first_pc4", pc_plus4_o, 32'h0040_0004);
      for (int i = 0; i < 2; i++) begin                  // delayed ack 2,3
         step(0, 0, 0, 0, 1);
         chk("wait_hold", {31'd0, pc_hold_o}, 32'd1);
         chk("wait_addr", imem_addr_o, 32'h0040_0004);
      end
      step(1, 32'hAAAA_0001, 0, 0, 1);                   // ack into skid
      chk("skid_hold", {31'd0, pc_hold_o}, 32'd0);
      step(0, 0, 0, 0, 1);                               // FULL, stalled
      chk("full_req", {31'd0, imem_req_o}, 32'd0);
      chk("full_instr", instr_o, 32'h2008_0005);
      step(0, 0, 0, 0, 0);                               // FULL, release
      step(0, 0, 1, 32'hFFFF_FFFC, 0);                   // redirect, no ack
      chk("skid_out", instr_o, 32'hAAAA_0001);
      chk("skid_pc", pc_o, 32'h0040_0004);
      chk("req_resume", {31'd0, imem_req_o}, 32'd1);
      chk("redir_hold", {31'd0, pc_hold_o}, 32'd0);
      step(1, 32'hDEAD_BEEF, 0, 0, 0);                   // DRAIN, ack
      chk("drain_valid", {31'd0, valid_o}, 32'd0);
      chk("drain_addr", imem_addr_o, 32'h0040_0008);
      step(1, 32'h1111_2222, 0, 0, 0);                   // fetch at target
      chk("drop_valid", {31'd0, valid_o}, 32'd0);
      chk("tgt_addr", imem_addr_o, 32'hFFFF_FFFC);
      step(1, 32'h5555_5555, 1, 32'h0040_0100, 0);       // redirect + ack
      chk("wrap_instr", instr_o, 32'h1111_2222);
      chk("wrap_pc4", pc_plus4_o, 32'h0000_0000);
      chk("ra_hold", {31'd0, pc_hold_o}, 32'd0);
      step(0, 0, 0, 0, 0);
      chk("ra_valid", {31'd0, valid_o}, 32'd0);
      chk("ra_addr", imem_addr_o, 32'h0040_0100);

      // Randomized traffic with a reset in the middle of it.
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) do_reset();
         r = $urandom();
         tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
         step($urandom_range(0, 99) < 55, $urandom(), $urandom_range(0, 99) < 8,
              tgt, $urandom_range(0, 99) < 40);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter N_BITS, default 32, SHALL set the width of every address, PC and instruction port.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; assertion SHALL force the reset state immediately, independent of clk.
REQ-004 pc_i  input  N_BITS  current PC value from the program counter register.
REQ-005 pc_hold_o  output  1  1 = PC SHALL hold; 0 = PC loads its next value (drives the PC enable, active-low update).
REQ-006 imem_req_o  output  1  instruction-memory read request.
REQ-007 imem_addr_o  output  N_BITS  instruction-memory read address.
REQ-008 imem_ack_i  input  1  memory returns imem_rdata_i this cycle; SHALL be ignored while imem_req_o=0.
REQ-009 imem_rdata_i  input  N_BITS  fetched instruction word.
REQ-010 redirect_i  input  1  branch/jump taken; flushes the fetch path, PC loads the target this cycle.
REQ-011 id_stall_i  input  1  decode cannot accept; SHALL be ignored while valid_o=0.
REQ-012 valid_o  output  1  instr_o/pc_o/pc_plus4_o hold a valid fetched instruction.
REQ-013 instr_o, pc_o, pc_plus4_o  output  N_BITS each  registered instruction, its address, and address+4.

Function
REQ-014 FSM states SHALL be IDLE, REQ, FULL, DRAIN.
REQ-015 IDLE: imem_req_o=0, pc_hold_o=1; next state REQ unconditionally.
REQ-016 REQ: imem_req_o=1, imem_addr_o=pc_i; addr_q SHALL capture pc_i every cycle.
REQ-017 REQ without ack and without redirect: pc_hold_o=1 (address stable until ack), stay REQ.
REQ-018 REQ with ack, no redirect, output slot free (valid_o=0 or id_stall_i=0): next cycle instr_o=imem_rdata_i, pc_o=pc_i, pc_plus4_o=pc_i+4, valid_o=1; pc_hold_o=0; stay REQ (back-to-back fetch, one instruction per cycle at zero memory latency).
REQ-019 REQ with ack, no redirect, slot occupied (valid_o=1 and id_stall_i=1): word and pc_i SHALL be captured into a one-entry skid buffer; pc_hold_o=0; next state FULL.
REQ-020 FULL: imem_req_o=0, pc_hold_o=1; when id_stall_i=0, outputs SHALL load from skid (valid_o stays 1) and next state REQ.
REQ-021 Output slot with no new load: valid_o SHALL clear when id_stall_i=0; outputs SHALL be held unchanged while valid_o=1 and id_stall_i=1.
REQ-022 redirect_i=1 in any non-IDLE state: pc_hold_o=0; valid_o SHALL be 0 next cycle; skid discarded; any ack that cycle discarded.
REQ-023 redirect_i in REQ without ack: request still outstanding, next state DRAIN; redirect in REQ with ack or in FULL: next state REQ.
REQ-024 DRAIN: imem_req_o=1, imem_addr_o=addr_q (stable), pc_hold_o=1 unless redirect_i; on ack the data SHALL be discarded and next state REQ; redirect in DRAIN stays DRAIN.
REQ-025 Once imem_req_o rises it SHALL remain 1 with unchanged imem_addr_o until the ack cycle.
REQ-026 pc_plus4_o SHALL be modulo 2^N_BITS (0xFFFF_FFFC -> 0x0000_0000).
REQ-027 At most one instruction SHALL be held in skid; no fetch issues while FULL.

Reset
REQ-028 While reset=1: state IDLE, valid_o=0, instr_o=pc_o=pc_plus4_o=0, skid empty, addr_q=0, imem_req_o=0, pc_hold_o=1.
REQ-029 Reset mid-request SHALL abandon the outstanding request; first request after reset release SHALL use pc_i (0x0040_0000).

Verification
REQ-030 Reset release, pc_i=0x0040_0000, ack same cycle as req, rdata=0x2008_0005 -> next cycle valid_o=1, instr_o=0x2008_0005, pc_o=0x0040_0000, pc_plus4_o=0x0040_0004.
REQ-031 Ack delayed 3 cycles -> pc_hold_o=1 and imem_addr_o constant for 3 cycles, pc_hold_o=0 only on ack cycle.
REQ-032 id_stall_i=1 with valid_o=1, ack arrives -> FULL, imem_req_o=0, outputs unchanged; id_stall_i=0 -> skid word on instr_o, req resumes next cycle.
REQ-033 redirect_i while request outstanding to 0x0040_0008 -> valid_o=0, DRAIN holds addr 0x0040_0008, ack data never appears on instr_o; next request uses target pc_i.
REQ-034 redirect_i and ack same cycle -> data discarded, valid_o=0, pc_hold_o=0, state REQ.
REQ-035 pc_i=0xFFFF_FFFC fetched -> pc_plus4_o=0x0000_0000.
